fft_butterfly_r2: RTL and testbench
===================================

// Module: fft_butterfly_r2
// PURPOSE
//  Radix-2 DIT butterfly stage for the FFT pipeline; sits directly upstream of and
//  around the twiddle multiplier (multComplexE-style en/outValid handshake).
//  Accepts a pair (A,B) plus twiddle index, issues B and the index to the multiplier,
//  and forms Y0 = A + W*B, Y1 = A - W*B once the multiplier reports done.
// PARAMETERS
//  NFFT_LOG2   6   log2(FFT size); twiddle index width = NFFT_LOG2-1
//  DATA_W      16  sample width (two's complement, I and Q each)
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          A/B/in_fi valid
//  in_ready     out  1          block can accept a pair
//  in_a_i/q     in   DATA_W     butterfly top input
//  in_b_i/q     in   DATA_W     butterfly bottom input (to be twiddled)
//  in_fi        in   NFFT_LOG2-1 twiddle index k (W = e^-j2pi k/NFFT)
//  tw_en        out  1          one-cycle start pulse to multiplier
//  tw_data_i/q  out  DATA_W     B held stable from tw_en until capture
//  tw_fi        out  16         zero-extended in_fi, held like tw_data
//  tw_ready     in   1          multiplier outValid: 1=idle/result valid, 0=busy
//  tw_res_i/q   in   DATA_W     multiplier W*B (minus output)
//  out_valid    out  1          Y0/Y1 valid
//  out_ready    in   1          downstream accepts Y0/Y1
//  out_y0_i/q   out  DATA_W     A + W*B
//  out_y1_i/q   out  DATA_W     A - W*B
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1, tw_en=0, out_valid=0, all data regs 0.
//  - Reset mid-operation aborts immediately; the in-flight pair is discarded and
//    multiplier state is not touched (it is reset by its own domain).
//  - FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> OUT -> IDLE.
//    IDLE: in_ready=1; on in_valid latch A, B, fi -> ISSUE (in_ready=0 next cycle).
//    ISSUE: wait for tw_ready=1; then tw_en=1 for exactly one cycle -> WAIT_BUSY.
//    WAIT_BUSY: wait for tw_ready=0 (multiplier acknowledged) -> WAIT_DONE.
//    WAIT_DONE: on tw_ready=1 capture tw_res, compute Y0/Y1 -> OUT the next cycle.
//    OUT: out_valid=1, outputs stable; on out_ready=1 -> IDLE, out_valid=0 next cycle.
//  - No new pair accepted while state!=IDLE (single pair in flight).
//  - Latency in_valid accept -> out_valid: 4 cycles + multiplier busy time.
//  - Arithmetic: sums in DATA_W+1 bits, sign-extended operands.
//  - Output result path: one register stage after capture; no combinational
//    path from tw_res or out_ready to any output.
//  - tw_data/tw_fi unchanged from ISSUE until WAIT_DONE capture.
// CONFIGURATION
//  FFT_BFLY_SCALE_EN defined: Y = (DATA_W+1 sum) >>> 1 (arithmetic, truncation
//    toward -inf); never overflows; per-stage 1/2 scaling.
//  Not defined: Y = sum saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
// TESTING (bench uses behavioural multiplier: outValid drops 1 cycle after en,
//  rises after N=6 cycles, returns exact W*B)
//  1 fi=0, A=(1000,0), B=(200,100) -> Y0=(1200,100), Y1=(800,-100);
//    with FFT_BFLY_SCALE_EN Y0=(600,50), Y1=(400,-50).
//  2 fi=NFFT/4 (W=-j), A=(0,0), B=(100,0) -> Y0=(0,-100), Y1=(0,100).
//  3 fi=0, A=(32000,-32000), B=(32000,-32000), no macro -> Y0=(32767,-32768),
//    Y1=(0,0); with macro Y0=(32000,-32000).
//  4 out_ready held 0 for 10 cycles -> out_valid stays 1, Y stable, in_ready=0,
//    tw_en never pulses; release -> accepts next pair next IDLE cycle.
//  5 tw_ready held 0 at ISSUE for 5 cycles -> tw_en stays 0 until tw_ready=1,
//    then exactly one pulse; back-to-back 8 pairs -> 8 outputs in order.
//  6 rst_n low during WAIT_DONE -> async clear: out_valid=0, in_ready=1, tw_en=0;
//    next pair after release processes correctly.

Source files
------------

// File: rtl/fft_butterfly_r2_if.sv
// fft_butterfly_r2_if: input pair, twiddle multiplier and output bus of the radix-2 butterfly; slave = butterfly, master = environment
interface fft_butterfly_r2_if #(
  parameter int NFFT_LOG2 = 6,
  parameter int DATA_W    = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_a_i;
  logic [DATA_W-1:0]    in_a_q;
  logic [DATA_W-1:0]    in_b_i;
  logic [DATA_W-1:0]    in_b_q;
  logic [NFFT_LOG2-2:0] in_fi;
  logic                 tw_en;
  logic [DATA_W-1:0]    tw_data_i;
  logic [DATA_W-1:0]    tw_data_q;
  logic [15:0]          tw_fi;
  logic                 tw_ready;
  logic [DATA_W-1:0]    tw_res_i;
  logic [DATA_W-1:0]    tw_res_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_y0_i;
  logic [DATA_W-1:0]    out_y0_q;
  logic [DATA_W-1:0]    out_y1_i;
  logic [DATA_W-1:0]    out_y1_q;
  modport slave (
    input  in_valid, in_a_i, in_a_q, in_b_i, in_b_q, in_fi, tw_ready, tw_res_i, tw_res_q, out_ready,
    output in_ready, tw_en, tw_data_i, tw_data_q, tw_fi, out_valid, out_y0_i, out_y0_q, out_y1_i, out_y1_q
  );
  modport master (
    output in_valid, in_a_i, in_a_q, in_b_i, in_b_q, in_fi, tw_ready, tw_res_i, tw_res_q, out_ready,
    input  in_ready, tw_en, tw_data_i, tw_data_q, tw_fi, out_valid, out_y0_i, out_y0_q, out_y1_i, out_y1_q
  );
endinterface

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: radix-2 DIT butterfly Y0=A+W*B, Y1=A-W*B around an en/outValid twiddle multiplier; ports clk, rst_n (async active-low), bus (fft_butterfly_r2_if.slave); FFT_BFLY_SCALE_EN selects >>>1 scaling instead of saturation
module fft_butterfly_r2 #(
  parameter int NFFT_LOG2 = 6,
  parameter int DATA_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  fft_butterfly_r2_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUT} state_t;
  state_t            state_q;
  logic              in_ready_q;
  logic              tw_en_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] a_i_q;
  logic [DATA_W-1:0] a_q_q;
  logic [DATA_W-1:0] b_i_q;
  logic [DATA_W-1:0] b_q_q;
  logic [15:0]       fi_q;
  logic [DATA_W-1:0] y0_i_q;
  logic [DATA_W-1:0] y0_q_q;
  logic [DATA_W-1:0] y1_i_q;
  logic [DATA_W-1:0] y1_q_q;
  logic [DATA_W-1:0] y0_i_d;
  logic [DATA_W-1:0] y0_q_d;
  logic [DATA_W-1:0] y1_i_d;
  logic [DATA_W-1:0] y1_q_d;
  // Reduce a DATA_W+1 bit sum back to DATA_W bits.
  function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W:0] s);
`ifdef FFT_BFLY_SCALE_EN
    return DATA_W'($signed(s) >>> 1);
`else
    return (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
`endif
  endfunction
  // Operands sign-extended by one bit so the sum cannot wrap before fmt.
  always_comb begin
    y0_i_d = fmt({a_i_q[DATA_W-1], a_i_q} + {bus.tw_res_i[DATA_W-1], bus.tw_res_i});
    y0_q_d = fmt({a_q_q[DATA_W-1], a_q_q} + {bus.tw_res_q[DATA_W-1], bus.tw_res_q});
    y1_i_d = fmt({a_i_q[DATA_W-1], a_i_q} - {bus.tw_res_i[DATA_W-1], bus.tw_res_i});
    y1_q_d = fmt({a_q_q[DATA_W-1], a_q_q} - {bus.tw_res_q[DATA_W-1], bus.tw_res_q});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      tw_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      a_i_q       <= '0;
      a_q_q       <= '0;
      b_i_q       <= '0;
      b_q_q       <= '0;
      fi_q        <= '0;
      y0_i_q      <= '0;
      y0_q_q      <= '0;
      y1_i_q      <= '0;
      y1_q_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_i_q      <= bus.in_a_i;
          a_q_q      <= bus.in_a_q;
          b_i_q      <= bus.in_b_i;
          b_q_q      <= bus.in_b_q;
          fi_q       <= 16'(bus.in_fi);
          in_ready_q <= 1'b0;
          state_q    <= ISSUE;
        end
        ISSUE: if (bus.tw_ready) begin
          tw_en_q <= 1'b1;
          state_q <= WAIT_BUSY;
        end
        // tw_ready may still read 1 while the multiplier registers en; wait for it to drop.
        WAIT_BUSY: begin
          tw_en_q <= 1'b0;
          if (!bus.tw_ready) state_q <= WAIT_DONE;
        end
        WAIT_DONE: if (bus.tw_ready) begin
          y0_i_q      <= y0_i_d;
          y0_q_q      <= y0_q_d;
          y1_i_q      <= y1_i_d;
          y1_q_q      <= y1_q_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.tw_en     = tw_en_q;
  assign bus.tw_data_i = b_i_q;
  assign bus.tw_data_q = b_q_q;
  assign bus.tw_fi     = fi_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y0_i  = y0_i_q;
  assign bus.out_y0_q  = y0_q_q;
  assign bus.out_y1_i  = y1_i_q;
  assign bus.out_y1_q  = y1_q_q;
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: randomized and directed bench with behavioural multiplier and scoreboard for fft_butterfly_r2
module tb_fft_butterfly_r2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fft_butterfly_r2_if #(.NFFT_LOG2(6), .DATA_W(16)) bus ();
  fft_butterfly_r2 #(.NFFT_LOG2(6), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vecs = 0;
  int errs = 0;
  typedef struct {int y0i; int y0q; int y1i; int y1q;} exp_t;
  exp_t q[$];
  int last_bi, last_bq, last_fi;
  int en_cnt = 0;
  logic hold_busy = 1'b0;
  logic stall = 1'b0;
  logic rnd = 1'b0;
  task automatic chk(input string n, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // W = e^-j2pi k/64 for the exactly representable indices k=0 (W=1) and k=16 (W=-j).
  function automatic void wmul(input int k, input int bi, input int bq, output int wi, output int wq);
    wi = (k == 16) ? bq : bi;
    wq = (k == 16) ? -bi : bq;
  endfunction
  function automatic int fmt(input int s);
`ifdef FFT_BFLY_SCALE_EN
    return s >>> 1;
`else
    return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`endif
  endfunction
  // Behavioural multiplier: outValid drops the cycle after en, rises 6 cycles later with exact W*B.
  logic mult_rdy = 1'b1;
  int cnt = 0;
  logic [15:0] res_i = '0;
  logic [15:0] res_q = '0;
  always @(posedge clk) begin
    int wi, wq;
    if (bus.tw_en && mult_rdy) begin
      wmul(int'(bus.tw_fi), int'($signed(bus.tw_data_i)), int'($signed(bus.tw_data_q)), wi, wq);
      res_i <= 16'(wi);
      res_q <= 16'(wq);
      mult_rdy <= 1'b0;
      cnt <= 6;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mult_rdy <= 1'b1;
    end
  end
  assign bus.tw_ready = mult_rdy & ~hold_busy;
  assign bus.tw_res_i = res_i;
  assign bus.tw_res_q = res_q;
  always @(posedge clk) begin
    #1;
    bus.out_ready = stall ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
  end
  // Compare process: scoreboard push on input handshake, pop/compare on output handshake.
  logic held = 1'b0;
  int h0i, h0q, h1i, h1q;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      en_cnt = 0;
    end else begin
      if (bus.tw_en) begin
        en_cnt++;
        chk("tw_en_while_ready", int'(bus.tw_ready), 1);
        chk("tw_en_not_in_out", int'(bus.out_valid), 0);
        chk("tw_data_i", int'($signed(bus.tw_data_i)), last_bi);
        chk("tw_data_q", int'($signed(bus.tw_data_q)), last_bq);
        chk("tw_fi", int'(bus.tw_fi), last_fi);
      end
      if (held && bus.out_valid) begin
        chk("hold_y0_i", int'($signed(bus.out_y0_i)), h0i);
        chk("hold_y0_q", int'($signed(bus.out_y0_q)), h0q);
        chk("hold_y1_i", int'($signed(bus.out_y1_i)), h1i);
        chk("hold_y1_q", int'($signed(bus.out_y1_q)), h1q);
        chk("hold_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.in_valid && bus.in_ready) begin
        int ai, aq, wi, wq;
        exp_t e;
        ai = int'($signed(bus.in_a_i));
        aq = int'($signed(bus.in_a_q));
        last_bi = int'($signed(bus.in_b_i));
        last_bq = int'($signed(bus.in_b_q));
        last_fi = int'(bus.in_fi);
        wmul(last_fi, last_bi, last_bq, wi, wq);
        e.y0i = fmt(ai + wi);
        e.y0q = fmt(aq + wq);
        e.y1i = fmt(ai - wi);
        e.y1q = fmt(aq - wq);
        q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_output: got out_valid=1 expected no pending pair");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("y0_i", int'($signed(bus.out_y0_i)), e.y0i);
          chk("y0_q", int'($signed(bus.out_y0_q)), e.y0q);
          chk("y1_i", int'($signed(bus.out_y1_i)), e.y1i);
          chk("y1_q", int'($signed(bus.out_y1_q)), e.y1q);
          chk("tw_en_pulses", en_cnt, 1);
          en_cnt = 0;
        end
      end
      held = bus.out_valid && !bus.out_ready;
      h0i = int'($signed(bus.out_y0_i));
      h0q = int'($signed(bus.out_y0_q));
      h1i = int'($signed(bus.out_y1_i));
      h1q = int'($signed(bus.out_y1_q));
    end
  end
  task automatic send(input int ai, input int aq, input int bi, input int bq, input int k, output int n);
    bus.in_a_i = 16'(ai);
    bus.in_a_q = 16'(aq);
    bus.in_b_i = 16'(bi);
    bus.in_b_q = 16'(bq);
    bus.in_fi = 5'(k);
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_out();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.out_valid) return;
    end
    vecs++;
    errs++;
    $display("FAIL out_timeout: got out_valid=0 expected 1 within 300 cycles");
  endtask
  task automatic lit(input string n, input int y0i, input int y0q, input int y1i, input int y1q);
    chk({n, "_y0_i"}, int'($signed(bus.out_y0_i)), y0i);
    chk({n, "_y0_q"}, int'($signed(bus.out_y0_q)), y0q);
    chk({n, "_y1_i"}, int'($signed(bus.out_y1_i)), y1i);
    chk({n, "_y1_q"}, int'($signed(bus.out_y1_q)), y1q);
  endtask
  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid && bus.in_ready) begin
        @(posedge clk);
        #2;
        return;
      end
    end
    vecs++;
    errs++;
    $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
  endtask
  task automatic rand_pair();
    int n;
    send(int'($urandom_range(0, 65534)) - 32767, int'($urandom_range(0, 65534)) - 32767,
         int'($urandom_range(0, 65534)) - 32767, int'($urandom_range(0, 65534)) - 32767,
         ($urandom % 2) ? 16 : 0, n);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_a_i = '0;
    bus.in_a_q = '0;
    bus.in_b_i = '0;
    bus.in_b_q = '0;
    bus.in_fi = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_tw_en", int'(bus.tw_en), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y0_i", int'($signed(bus.out_y0_i)), 0);
    chk("rst_tw_data_i", int'($signed(bus.tw_data_i)), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    send(1000, 0, 200, 100, 0, n);
    wait_out();
`ifdef FFT_BFLY_SCALE_EN
    lit("t1", 600, 50, 400, -50);
`else
    lit("t1", 1200, 100, 800, -100);
`endif
    @(posedge clk);
    #2;
    send(0, 0, 100, 0, 16, n);
    wait_out();
`ifdef FFT_BFLY_SCALE_EN
    lit("t2", 0, -50, 0, 50);
`else
    lit("t2", 0, -100, 0, 100);
`endif
    @(posedge clk);
    #2;
    send(32000, -32000, 32000, -32000, 0, n);
    wait_out();
`ifdef FFT_BFLY_SCALE_EN
    lit("t3", 32000, -32000, 0, 0);
`else
    lit("t3", 32767, -32768, 0, 0);
`endif
    drain();
    stall = 1'b1;
    send(10, 20, 30, 40, 0, n);
    wait_out();
    repeat (10) begin
      @(negedge clk);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    stall = 1'b0;
    @(posedge clk);
    #2;
    send(5, 6, 7, 8, 16, n);
    chk("accept_after_release", n, 2);
    wait_out();
`ifdef FFT_BFLY_SCALE_EN
    lit("t4", 6, -1, -2, 6);
`else
    lit("t4", 13, -1, -3, 13);
`endif
    drain();
    hold_busy = 1'b1;
    send(-300, 400, 123, -77, 16, n);
    repeat (5) begin
      @(negedge clk);
      chk("busy_no_tw_en", int'(bus.tw_en), 0);
    end
    hold_busy = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) rand_pair();
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) rand_pair();
    rnd = 1'b0;
    drain();
    send(111, 222, 333, 444, 0, n);
    for (int i = 0; i < 50 && !bus.tw_en; i++) @(negedge clk);
    chk("t6_tw_en_seen", int'(bus.tw_en), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_in_ready", int'(bus.in_ready), 1);
    chk("t6_tw_en", int'(bus.tw_en), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    send(1000, 0, 200, 100, 0, n);
    wait_out();
`ifdef FFT_BFLY_SCALE_EN
    lit("t6", 600, 50, 400, -50);
`else
    lit("t6", 1200, 100, 800, -100);
`endif
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
